medidor_periodo: RTL and testbench
==================================

Name: medidor_periodo

Overview:
Measures the period of the spirometer turbine pulse train, counted in iCE-qualified iClk cycles between consecutive rising edges of the asynchronous input iPulse. Each completed period is published on oPeriod with a valid/acknowledge handshake. The block sits on the opposite end of the divisor tick: it consumes a pulse stream and recovers its period. It also flags stalled flow (timeout), glitches (periods that are too short) and unread results (overrun).

Parameters:
COUNT_W, 24, width of the period counter and of oPeriod.
TIMEOUT, 12500000, largest measurable period; reaching it with no edge declares a stall.
MIN_PERIOD, 16, periods shorter than this are rejected as glitches.

Ports:
iClk  input  1  system clock; single clock domain.
iReset  input  1  synchronous, active-high reset.
iCE  input  1  clock enable; the synchronizer, edge detect, counter and FSM advance only when iCE=1.
iPulse  input  1  asynchronous turbine pulse.
iAck  input  1  consumer acknowledge; sampled on every iClk, regardless of iCE.
oPeriod  output  COUNT_W  last accepted period, in enabled cycles.
oValid  output  1  oPeriod holds an unread result.
oTimeout  output  1  no edge seen within TIMEOUT cycles; flow is stalled.
oOverrun  output  1  sticky flag: a new result overwrote an unacknowledged one.

Behaviour:
- Reset (synchronous, active-high):
  - State IDLE; count=0; synchronizer flops=0.
  - oPeriod=0, oValid=0, oTimeout=0, oOverrun=0.
  - Reset asserted mid-measurement discards the partial count.
- Input conditioning, on enabled cycles only:
  - iPulse -> s1 -> s2 -> s3; edge = s2 & ~s3.
  - An edge is detected 2 enabled cycles after iPulse rises; the latency cancels in period differences.
- FSM, updating on iCE=1 only; iCE=0 holds all state, count and flags.
- IDLE:
  - edge -> count<=1, go MEASURE.
  - No period is published for the first edge.
- MEASURE, with edge:
  - count<MIN_PERIOD: glitch, edge ignored, count<=count+1.
  - count>=MIN_PERIOD: oPeriod<=count, oValid<=1, count<=1.
  - An edge exactly at count==TIMEOUT is a valid period; the edge wins over timeout.
- MEASURE, no edge:
  - count==TIMEOUT: go STALL, oTimeout<=1, count holds.
  - Otherwise count<=count+1.
- STALL:
  - edge -> oTimeout<=0, count<=1, go MEASURE; no publish.
  - Otherwise hold.
- Period definition: pulses every P enabled cycles (MIN_PERIOD<=P<=TIMEOUT) give oPeriod=P.
- Handshake (every iClk):
  - publish = enabled cycle with an accepted edge.
  - publish & iAck: oValid stays 1 with the new value; no overrun.
  - publish & oValid & ~iAck: oOverrun<=1; oPeriod is replaced.
  - iAck & ~publish: oValid<=0, oOverrun<=0.
  - iAck while oValid=0: no effect.
- Arithmetic: count is unsigned COUNT_W bits, saturating at TIMEOUT, so it never wraps. Elaboration requires TIMEOUT < 2^COUNT_W and 2 <= MIN_PERIOD <= TIMEOUT.
- oPeriod is held stable while oValid=1, except when a publish replaces it (the overrun case).

Decomposition:
- Shared package (espirometro_pkg):
  - State encoding IDLE=2'd0, MEASURE=2'd1, STALL=2'd2.
  - Default COUNT_W and TIMEOUT constants, shared with divisor so tick and timeout stay consistent.
- One sub-module: sincronizador_flanco (3-flop enabled synchronizer plus rising-edge detect), reused for other sensor inputs.

Test Plan:
Bench parameters TIMEOUT=100, MIN_PERIOD=4, iCE=1 unless stated.
- Reset then square pulses every 20 cycles, iAck pulsed after each oValid -> first edge gives no output; every following result has oPeriod=20 and oValid=1; oOverrun=0.
- Pulses every 20 cycles with iCE toggling 1/0 (50%) and iPulse held for ≥4 clocks -> oPeriod=10 (enabled cycles only).
- Extra edge 2 cycles after a valid edge within a 20-cycle train -> glitch ignored; oPeriod stays 20.
- Stop pulses after the second edge -> oTimeout=1 exactly 100 enabled cycles after the last edge; the next edge clears oTimeout with no publish; the edge after that, 30 cycles later, gives oPeriod=30.
- Period exactly 100 -> oPeriod=100 and oTimeout stays 0. Period 101 -> oTimeout=1 and no publish.
- Two results with no iAck -> oOverrun=1 and oPeriod shows the second value. iAck -> oValid=0, oOverrun=0. Publish and iAck in the same cycle -> oValid=1, oOverrun=0.

Source files
------------

// File: rtl/espirometro_pkg.sv
// Shared spirometer definitions: FSM encoding and default sizing
// common to the tick divider and the period meter.
package espirometro_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALL   = 2'd2
  } state_t;

  localparam int COUNT_W_DEF    = 24;
  localparam int TIMEOUT_DEF    = 12500000;
  localparam int MIN_PERIOD_DEF = 16;

  function automatic bit params_ok(
    input int cw,
    input int to,
    input int mp
  );
    longint lim;
    lim = longint'(1) << cw;
    return (longint'(to) < lim) && (mp >= 2) && (mp <= to);
  endfunction

endpackage

// File: rtl/medidor_periodo_if.sv
// Result handshake between the period meter and its consumer.
// The meter drives result and flags; the consumer drives iAck.
interface medidor_periodo_if
  import espirometro_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF
);

  logic [COUNT_W-1:0] oPeriod;
  logic               oValid;
  logic               oTimeout;
  logic               oOverrun;
  logic               iAck;

  modport master (
    output oPeriod,
    output oValid,
    output oTimeout,
    output oOverrun,
    input  iAck
  );

  modport slave (
    input  oPeriod,
    input  oValid,
    input  oTimeout,
    input  oOverrun,
    output iAck
  );

endinterface

// File: rtl/sincronizador_flanco.sv
// Enabled 3-flop synchronizer with rising-edge detect for async
// sensor inputs; the edge pulse is valid for one enabled cycle.
module sincronizador_flanco (
  input  logic iClk,
  input  logic iReset,
  input  logic iCE,
  input  logic iAsync,
  output logic oEdge
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else if (iCE) begin
      r_s1 <= iAsync;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign oEdge = r_s2 & ~r_s3;

endmodule

// File: rtl/medidor_periodo.sv
// Turbine pulse period meter: counts enabled cycles between rising
// edges, rejects glitches, flags stalls and unread overwrites.
module medidor_periodo
  import espirometro_pkg::*;
#(
  parameter int COUNT_W    = COUNT_W_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
  input  logic               iClk,
  input  logic               iReset,
  input  logic               iCE,
  input  logic               iPulse,
  medidor_periodo_if.master  bus
);

  localparam logic [COUNT_W-1:0] LP_TO  = COUNT_W'(TIMEOUT);
  localparam logic [COUNT_W-1:0] LP_MIN = COUNT_W'(MIN_PERIOD);
  localparam logic [COUNT_W-1:0] LP_ONE = COUNT_W'(1);

  if (!params_ok(COUNT_W, TIMEOUT, MIN_PERIOD)) begin : g_bad_params
    $error("medidor_periodo: invalid COUNT_W/TIMEOUT/MIN_PERIOD");
  end

  logic w_edge;
  logic w_pub;

  state_t             r_state;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] r_period;
  logic               r_valid;
  logic               r_timeout;
  logic               r_overrun;

  sincronizador_flanco u_sync (
    .iClk   (iClk),
    .iReset (iReset),
    .iCE    (iCE),
    .iAsync (iPulse),
    .oEdge  (w_edge)
  );

  assign w_pub = iCE & w_edge
               & (r_state == MEASURE)
               & (r_count >= LP_MIN);

  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (iCE) begin
        case (r_state)
          IDLE: begin
            if (w_edge) begin
              r_count <= LP_ONE;
              r_state <= MEASURE;
            end
          end
          MEASURE: begin
            // An edge at exactly TIMEOUT still closes a valid period
            if (w_edge) begin
              if (r_count < LP_MIN) r_count <= r_count + LP_ONE;
              else                  r_count <= LP_ONE;
            end else if (r_count == LP_TO) begin
              r_state   <= STALL;
              r_timeout <= 1'b1;
            end else begin
              r_count <= r_count + LP_ONE;
            end
          end
          STALL: begin
            if (w_edge) begin
              r_timeout <= 1'b0;
              r_count   <= LP_ONE;
              r_state   <= MEASURE;
            end
          end
          default: begin
            r_state <= IDLE;
            r_count <= '0;
          end
        endcase
      end

      // Consumer side runs every clock, independent of iCE
      if (w_pub) begin
        r_period <= r_count;
        r_valid  <= 1'b1;
        if (r_valid & ~bus.iAck) r_overrun <= 1'b1;
      end else if (bus.iAck) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.oPeriod  = r_period;
  assign bus.oValid   = r_valid;
  assign bus.oTimeout = r_timeout;
  assign bus.oOverrun = r_overrun;

endmodule

// File: tb/tb_medidor_periodo.sv
// Directed bench for medidor_periodo with TIMEOUT=100, MIN_PERIOD=4;
// every step drives inputs 1 time unit after the rising clock edge.
module tb_medidor_periodo;
  import espirometro_pkg::*;

  localparam int CW = 16;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic ce    = 1'b1;
  logic pulse = 1'b0;
  logic ack   = 1'b0;
  bit   tog   = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  medidor_periodo_if #(.COUNT_W(CW)) bus ();
  assign bus.iAck = ack;

  medidor_periodo #(
    .COUNT_W    (CW),
    .TIMEOUT    (100),
    .MIN_PERIOD (4)
  ) dut (
    .iClk   (clk),
    .iReset (rst),
    .iCE    (ce),
    .iPulse (pulse),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    if (tog) ce = ~ce;
    @(posedge clk);
    #1;
  endtask

  // One pulse period of len clocks, high for w clocks; optional
  // ack on clock ack_i and a narrow extra pulse on clock 2.
  task automatic run(input int len, input int w,
                     input int ack_i, input bit glitch);
    for (int i = 0; i < len; i++) begin
      pulse = (i < w) || (glitch && i == 2);
      ack   = (i == ack_i);
      step();
    end
    pulse = 1'b0;
    ack   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tog = 1'b0; ce = 1'b1;
    pulse = 1'b0; ack = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state and basic 20-cycle train
    do_reset();
    chk("rst_period",  32'(bus.oPeriod),  0);
    chk("rst_valid",   32'(bus.oValid),   0);
    chk("rst_timeout", 32'(bus.oTimeout), 0);
    chk("rst_overrun", 32'(bus.oOverrun), 0);
    run(20, 5, -1, 0);
    chk("first_edge_novalid", 32'(bus.oValid), 0);
    run(20, 5, -1, 0);
    chk("p20_valid",   32'(bus.oValid),   1);
    chk("p20_period",  32'(bus.oPeriod),  20);
    chk("p20_overrun", 32'(bus.oOverrun), 0);
    run(20, 5, 0, 0);
    chk("p20b_valid",   32'(bus.oValid),   1);
    chk("p20b_period",  32'(bus.oPeriod),  20);
    chk("p20b_overrun", 32'(bus.oOverrun), 0);
    // iCE low freezes the meter but iAck still clears oValid
    ce = 1'b0;
    run(200, 1, 0, 0);
    chk("ce0_ack_valid", 32'(bus.oValid),   0);
    chk("ce0_timeout",   32'(bus.oTimeout), 0);
    chk("ce0_period",    32'(bus.oPeriod),  20);

    // 50% clock enable: 20 clocks = 10 enabled cycles
    do_reset();
    tog = 1'b1;
    run(20, 6, -1, 0);
    chk("ce50_first_novalid", 32'(bus.oValid), 0);
    run(20, 6, -1, 0);
    chk("ce50_valid",  32'(bus.oValid),  1);
    chk("ce50_period", 32'(bus.oPeriod), 10);
    run(20, 6, 0, 0);
    chk("ce50b_period",  32'(bus.oPeriod),  10);
    chk("ce50b_overrun", 32'(bus.oOverrun), 0);

    // Glitch 2 cycles after a valid edge is ignored
    do_reset();
    run(20, 1, -1, 0);
    run(20, 1, -1, 1);
    chk("gl_valid",  32'(bus.oValid),  1);
    chk("gl_period", 32'(bus.oPeriod), 20);
    run(20, 1, 0, 0);
    chk("gl_after_period",  32'(bus.oPeriod),  20);
    chk("gl_after_overrun", 32'(bus.oOverrun), 0);

    // Stall: timeout 100 enabled cycles after the last edge
    do_reset();
    run(20, 1, -1, 0);
    run(20, 1, -1, 0);
    chk("to_pre_period", 32'(bus.oPeriod), 20);
    ack = 1'b1;
    step();
    ack = 1'b0;
    for (int i = 0; i < 81; i++) step();
    chk("to_not_yet", 32'(bus.oTimeout), 0);
    step();
    chk("to_set", 32'(bus.oTimeout), 1);
    run(30, 1, -1, 0);
    chk("to_cleared",  32'(bus.oTimeout), 0);
    chk("to_nopublish", 32'(bus.oValid),  0);
    run(30, 1, -1, 0);
    chk("to_p30_valid",  32'(bus.oValid),  1);
    chk("to_p30_period", 32'(bus.oPeriod), 30);

    // Boundary: period 100 accepted, period 101 stalls
    do_reset();
    run(100, 1, -1, 0);
    run(101, 1, -1, 0);
    chk("p100_valid",   32'(bus.oValid),   1);
    chk("p100_period",  32'(bus.oPeriod),  100);
    chk("p100_timeout", 32'(bus.oTimeout), 0);
    pulse = 1'b1;
    ack   = 1'b1;
    step();
    ack = 1'b0;
    step();
    chk("p101_timeout", 32'(bus.oTimeout), 1);
    chk("p101_acked",   32'(bus.oValid),   0);
    step();
    pulse = 1'b0;
    chk("p101_to_clear", 32'(bus.oTimeout), 0);
    chk("p101_nopub",    32'(bus.oValid),   0);

    // Overrun, ack clear, and publish coinciding with ack
    do_reset();
    run(20, 1, -1, 0);
    run(30, 1, -1, 0);
    chk("ov_first_period", 32'(bus.oPeriod), 20);
    run(20, 1, -1, 0);
    chk("ov_flag",   32'(bus.oOverrun), 1);
    chk("ov_period", 32'(bus.oPeriod),  30);
    chk("ov_valid",  32'(bus.oValid),   1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ack_valid",   32'(bus.oValid),   0);
    chk("ack_overrun", 32'(bus.oOverrun), 0);
    run(20, 1, -1, 0);
    chk("p21_period", 32'(bus.oPeriod), 21);
    chk("p21_valid",  32'(bus.oValid),  1);
    run(20, 1, 2, 0);
    chk("pubAck_valid",   32'(bus.oValid),   1);
    chk("pubAck_overrun", 32'(bus.oOverrun), 0);
    chk("pubAck_period",  32'(bus.oPeriod),  20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
